// File: rtl/instr_loader_if.sv
// Byte-stream and instruction-memory IO-port bundle for instr_loader.
// master = loader side (consumes bytes, drives memory); slave = environment side.
interface instr_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        io_sel;
    logic        we;
    logic        en;
    logic [31:0] addr_io;
    logic [31:0] din;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, io_sel, we, en, addr_io, din
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, io_sel, we, en, addr_io, din
    );
endinterface

// File: rtl/instr_loader.sv
// Boot-time loader: length-prefixed little-endian byte stream -> instruction memory writes.
// Optional macro LOADER_CHECKSUM_EN adds a trailing mod-256 payload checksum byte.
module instr_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 32768
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    instr_loader_if.master bus,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [31:0]    word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_FIN
    } state_t;

    state_t      r_state;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_shift;
    logic [31:0] r_len;
    logic [31:0] r_word_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_din;
    logic        r_rx_ready;
    logic        r_io_sel;
    logic        r_we;
    logic        r_en;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic        w_accept;
    logic        w_last_byte;
    logic [31:0] w_word;
    logic [31:0] w_cnt_inc;

    assign w_accept    = bus.rx_valid & r_rx_ready;
    assign w_last_byte = (r_byte_idx == 2'd3);
    // First three bytes sit in r_shift (oldest lowest), the 4th arrives on the bus.
    assign w_word      = {bus.rx_data, r_shift};
    assign w_cnt_inc   = r_word_cnt + 32'd1;

    // NOTE: every register below uses <= so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_byte_idx <= 2'd0;
            r_shift    <= 24'd0;
            r_len      <= 32'd0;
            r_word_cnt <= 32'd0;
            r_addr     <= 32'd0;
            r_din      <= 32'd0;
            r_rx_ready <= 1'b0;
            r_io_sel   <= 1'b0;
            r_we       <= 1'b0;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_word_cnt <= 32'd0;
                        r_byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        r_csum     <= 8'd0;
`endif
                        r_busy     <= 1'b1;
                        r_io_sel   <= 1'b1;
                        r_rx_ready <= 1'b1;
                        r_state    <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_shift    <= {bus.rx_data, r_shift[23:8]};
                        if (w_last_byte) begin
                            r_len <= w_word;
                            if (w_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                r_state    <= S_CSUM;
`else
                                r_state    <= S_FIN;
                                r_rx_ready <= 1'b0;
`endif
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_shift    <= {bus.rx_data, r_shift[23:8]};
`ifdef LOADER_CHECKSUM_EN
                        r_csum     <= r_csum + bus.rx_data;
`endif
                        if (w_last_byte) begin
                            r_state    <= S_WRITE;
                            r_rx_ready <= 1'b0;
                            // Out-of-range words are consumed but never strobed.
                            if (r_word_cnt < MAX_WORDS) begin
                                r_we   <= 1'b1;
                                r_en   <= 1'b1;
                                r_addr <= BASE_ADDR + (r_word_cnt << 2);
                                r_din  <= w_word;
                            end
                        end
                    end
                end

                S_WRITE: begin
                    r_we       <= 1'b0;
                    r_en       <= 1'b0;
                    r_word_cnt <= w_cnt_inc;
                    if (!r_we) begin
                        r_err <= 1'b1;
                    end
                    if (w_cnt_inc == r_len) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state    <= S_CSUM;
                        r_rx_ready <= 1'b1;
`else
                        r_state    <= S_FIN;
`endif
                    end else begin
                        r_state    <= S_DATA;
                        r_rx_ready <= 1'b1;
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_accept) begin
                        if (bus.rx_data != r_csum) begin
                            r_err <= 1'b1;
                        end
                        r_rx_ready <= 1'b0;
                        r_state    <= S_FIN;
                    end
                end
`endif

                S_FIN: begin
                    r_busy   <= 1'b0;
                    r_io_sel <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready = r_rx_ready;
    assign bus.io_sel   = r_io_sel;
    assign bus.we       = r_we;
    assign bus.en       = r_en;
    assign bus.addr_io  = r_addr;
    assign bus.din      = r_din;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign word_cnt     = r_word_cnt;

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader (DUT built with MAX_WORDS = 2).
// Handles both builds: with and without LOADER_CHECKSUM_EN.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] word_cnt;

    instr_loader_if bus_if ();

    instr_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus_if),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Passive monitor: logs write strobes and accepted bytes.
    logic [31:0] wr_addr [64];
    logic [31:0] wr_din  [64];
    int wr_total       = 0;
    int acc_total      = 0;
    int ready_in_write = 0;
    int we_en_diff     = 0;

    always @(posedge clk) begin
        if (bus_if.we === 1'b1) begin
            wr_addr[wr_total % 64] <= bus_if.addr_io;
            wr_din[wr_total % 64]  <= bus_if.din;
            wr_total               <= wr_total + 1;
        end
        if (bus_if.rx_valid && bus_if.rx_ready) acc_total <= acc_total + 1;
        if (bus_if.we && bus_if.rx_ready) ready_in_write <= ready_in_write + 1;
        if (bus_if.we !== bus_if.en) we_en_diff <= we_en_diff + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},     busy,            1'b0);
        chk({tag, "_done"},     done,            1'b0);
        chk({tag, "_err"},      err,             1'b0);
        chk({tag, "_word_cnt"}, word_cnt,        32'd0);
        chk({tag, "_io_sel"},   bus_if.io_sel,   1'b0);
        chk({tag, "_we"},       bus_if.we,       1'b0);
        chk({tag, "_en"},       bus_if.en,       1'b0);
        chk({tag, "_addr"},     bus_if.addr_io,  32'd0);
        chk({tag, "_din"},      bus_if.din,      32'd0);
        chk({tag, "_rx_ready"}, bus_if.rx_ready, 1'b0);
    endtask

    task automatic chk_write(input string tag, input int idx,
                             input logic [31:0] exp_addr, input logic [31:0] exp_din);
        chk({tag, "_addr"}, wr_addr[idx % 64], exp_addr);
        chk({tag, "_din"},  wr_din[idx % 64],  exp_din);
    endtask

    // Called at 1 time unit after a rising edge; returns at the same phase.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int tmo;
        if (gap > 0) begin
            bus_if.rx_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        tmo = 0;
        while (!bus_if.rx_ready && tmo < 20) begin
            @(posedge clk);
            #1;
            tmo++;
        end
        if (tmo >= 20) chk("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input int gmax);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], (gmax == 0) ? 0 : int'($urandom_range(0, gmax)));
        end
    endtask

    function automatic logic [7:0] bsum(input logic [31:0] w);
        return w[7:0] + w[15:8] + w[23:16] + w[31:24];
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Full session: length, nw payload words, then (if enabled) checksum byte.
    task automatic load(input logic [31:0] n, input int nw,
                        input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                        input int gmax, input logic bad_csum);
        logic [7:0] sum;
        sum = 8'd0;
        do_start();
        send_word(n, gmax);
        for (int i = 0; i < nw; i++) begin
            logic [31:0] w;
            w = (i == 0) ? w0 : ((i == 1) ? w1 : w2);
            sum = sum + bsum(w);
            send_word(w, gmax);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum ^ {7'd0, bad_csum}, gmax);
`else
        if (bad_csum) sum = 8'd0;
`endif
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_done"}, done, 1'b1);
    endtask

    initial begin
        int base;
        int acc_base;
        int cyc;
        int extra;
`ifdef LOADER_CHECKSUM_EN
        extra = 1;
`else
        extra = 0;
`endif

        // Reset state
        rst             = 1'b1;
        start           = 1'b0;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_ready", bus_if.rx_ready, 1'b0);

        // Two-word load, back-to-back bytes, with a byte held valid across WRITE
        base     = wr_total;
        acc_base = acc_total;
        do_start();
        chk("start_io_sel", bus_if.io_sel,   1'b1);
        chk("start_busy",   busy,            1'b1);
        chk("start_ready",  bus_if.rx_ready, 1'b1);
        send_word(32'd2, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        chk("w1_we",        bus_if.we,       1'b1);
        chk("w1_en",        bus_if.en,       1'b1);
        chk("w1_addr",      bus_if.addr_io,  32'h0000_0000);
        chk("w1_din",       bus_if.din,      32'h1234_5678);
        chk("w1_ready_low", bus_if.rx_ready, 1'b0);
        chk("w1_io_sel",    bus_if.io_sel,   1'b1);
        send_word(32'hDEAD_BEEF, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(bsum(32'h1234_5678) + bsum(32'hDEAD_BEEF), 0);
`endif
        bus_if.rx_valid = 1'b0;
        wait_done("two", cyc);
        chk("two_nwrites", wr_total - base, 32'd2);
        chk_write("two_wr0", base,     32'h0000_0000, 32'h1234_5678);
        chk_write("two_wr1", base + 1, 32'h0000_0004, 32'hDEAD_BEEF);
        chk("two_err",      err,           1'b0);
        chk("two_word_cnt", word_cnt,      32'd2);
        chk("two_io_sel",   bus_if.io_sel, 1'b0);
        chk("two_busy",     busy,          1'b0);
        chk("two_accepted", acc_total - acc_base, 32'(12 + extra));
        chk("two_addr_hold", bus_if.addr_io, 32'h0000_0004);

        // Empty program
        base = wr_total;
        do_start();
        send_word(32'd0, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        bus_if.rx_valid = 1'b0;
        wait_done("empty", cyc);
        chk("empty_latency",  32'(cyc <= 2), 32'd1);
        chk("empty_nwrites",  wr_total - base, 32'd0);
        chk("empty_word_cnt", word_cnt, 32'd0);
        chk("empty_err",      err,      1'b0);

        // Same two-word stream with random gaps between bytes
        base     = wr_total;
        acc_base = acc_total;
        load(32'd2, 2, 32'h1234_5678, 32'hDEAD_BEEF, 32'd0, 5, 1'b0);
        wait_done("gaps", cyc);
        chk("gaps_nwrites", wr_total - base, 32'd2);
        chk_write("gaps_wr0", base,     32'h0000_0000, 32'h1234_5678);
        chk_write("gaps_wr1", base + 1, 32'h0000_0004, 32'hDEAD_BEEF);
        chk("gaps_err",      err,      1'b0);
        chk("gaps_accepted", acc_total - acc_base, 32'(12 + extra));

        // Overflow: three words into a two-word memory
        base = wr_total;
        load(32'd3, 3, 32'hA0B0_C0D0, 32'h0102_0304, 32'hCAFE_F00D, 0, 1'b0);
        wait_done("ovf", cyc);
        chk("ovf_nwrites", wr_total - base, 32'd2);
        chk_write("ovf_wr0", base,     32'h0000_0000, 32'hA0B0_C0D0);
        chk_write("ovf_wr1", base + 1, 32'h0000_0004, 32'h0102_0304);
        chk("ovf_err",      err,      1'b1);
        chk("ovf_word_cnt", word_cnt, 32'd3);
        chk("ovf_io_sel",   bus_if.io_sel, 1'b0);

        // Reset after six bytes, then a fresh full load
        do_start();
        chk("restart_clears_err", err, 1'b0);
        send_word(32'd2, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        bus_if.rx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("midrst");
        rst  = 1'b0;
        base = wr_total;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_we", wr_total - base, 32'd0);
        chk("midrst_idle",  busy, 1'b0);
        load(32'd2, 2, 32'h1234_5678, 32'hDEAD_BEEF, 32'd0, 0, 1'b0);
        wait_done("reload", cyc);
        chk("reload_nwrites", wr_total - base, 32'd2);
        chk_write("reload_wr0", base,     32'h0000_0000, 32'h1234_5678);
        chk_write("reload_wr1", base + 1, 32'h0000_0004, 32'hDEAD_BEEF);
        chk("reload_err", err, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum byte: words still written, error flagged
        base = wr_total;
        load(32'd2, 2, 32'h1234_5678, 32'hDEAD_BEEF, 32'd0, 0, 1'b1);
        wait_done("badsum", cyc);
        chk("badsum_nwrites", wr_total - base, 32'd2);
        chk("badsum_err",     err, 1'b1);
`endif

        chk("ready_low_in_write", ready_in_write, 32'd0);
        chk("we_en_equal",        we_en_diff,     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
